if_fetch_unit: RTL and testbench

//  Instruction-fetch stage between the PC source and inst_rom: owns the PC, drives rom_ce_o/rom_addr_o,

---
 rtl/if_fetch_unit_pkg.sv | 31 +++
 rtl/if_fetch_unit_fifo.sv | 73 +++++++
 rtl/if_fetch_unit.sv | 101 ++++++++++
 tb/tb_if_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Package for the instruction-fetch stage.
// Holds the shared bus widths, the reset and chip-enable encodings, the
// default prefetch depth, the layout of a prefetch FIFO entry, and two small
// helpers for branch-target alignment.
package if_fetch_unit_pkg;

  localparam int          INST_W        = 32;
  localparam int          ADDR_W        = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        RST_ENABLE    = 1'b0;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam int          IF_FIFO_DEPTH = 2;
  localparam logic [31:0] PC_STEP       = 32'd4;

  // One prefetched instruction together with the address it was read from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Branch targets are forced onto a word boundary before they are fetched.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
    return |a[1:0];
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Synchronous prefetch FIFO.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   i_flush  drop all entries; this wins over a push or pop in the same cycle
//   i_push   write i_wdata (ignored when full unless a pop also happens)
//   i_pop    retire the head entry (ignored when empty)
//   i_wdata  entry to write
//   o_rdata  head entry; meaningful only while o_empty is low
//   o_full   DEPTH entries held
//   o_empty  no entries held
// DEPTH must be a power of two so the pointers wrap on their own.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rd];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle, so the occupancy never exceeds DEPTH.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage needs no reset: it is never read while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM, and
// buffers fetched {pc, inst} pairs in a prefetch FIFO that feeds decode
// through a valid/ready handshake.
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   stall_i          hold the PC and stop fetching; decode keeps draining
//   branch_flag_i    redirect: flush the FIFO and load branch_target_i
//   branch_target_i  redirect address (low two bits are dropped)
//   rom_ce_o         ROM chip enable (registered, high once out of reset)
//   rom_addr_o       ROM byte address (zero while the ROM is disabled)
//   rom_data_i       ROM word, valid in the same cycle as rom_addr_o
//   id_valid_o       head entry available to decode
//   id_ready_i       decode takes the head this cycle
//   id_pc_o          head PC, zero when nothing is valid
//   id_inst_o        head instruction, zero (NOP) when nothing is valid
//   misalign_o       one-cycle pulse after a redirect whose target was not
//                    word aligned
import if_fetch_unit_pkg::*;

module if_fetch_unit #(
  parameter int          FIFO_DEPTH = IF_FIFO_DEPTH,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        misalign_o
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ce;
  logic              r_misalign;

  logic              w_pop;
  logic              w_fire;
  logic              w_full;
  logic              w_empty;
  fetch_entry_t      w_wentry;
  fetch_entry_t      w_head;
  logic [$bits(fetch_entry_t)-1:0] w_head_raw;

  assign w_pop  = id_valid_o & id_ready_i;
  // A fetch needs room, either a free slot or the head leaving this cycle.
  // A redirect suppresses the fetch because the current PC is on the wrong path.
  assign w_fire = r_ce & ~stall_i & ~branch_flag_i & (~w_full | w_pop);

  assign w_wentry.pc   = r_pc;
  assign w_wentry.inst = rom_data_i;

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (branch_flag_i),
    .i_push  (w_fire),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = w_head_raw;

  // Stale storage is never exposed: decode sees zeros whenever nothing is valid.
  assign id_valid_o = ~w_empty;
  assign id_pc_o    = id_valid_o ? w_head.pc   : ZERO_WORD;
  assign id_inst_o  = id_valid_o ? w_head.inst : ZERO_WORD;

  assign rom_ce_o   = r_ce;
  assign rom_addr_o = (r_ce == CHIP_ENABLE) ? r_pc : ZERO_WORD;
  assign misalign_o = r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_pc       <= RESET_PC;
      r_ce       <= CHIP_DISABLE;
      r_misalign <= 1'b0;
    end else begin
      r_ce       <= CHIP_ENABLE;
      r_misalign <= branch_flag_i & is_misaligned(branch_target_i);
      if (branch_flag_i)
        r_pc <= word_align(branch_target_i);
      else if (w_fire)
        r_pc <= r_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, br, ready;
  logic [31:0] tgt;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_data;
  logic        id_valid, misalign;
  logic [31:0] id_pc, id_inst;

  // Second instance checks the PC wrap from a high RESET_PC.
  logic        rst2, rom_ce2, id_valid2, misalign2;
  logic [31:0] rom_addr2, rom_data2, id_pc2, id_inst2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_data  = rom(rom_addr);
  assign rom_data2 = rom(rom_addr2);

  if_fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br),
    .branch_target_i(tgt), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .id_valid_o(id_valid), .id_ready_i(ready),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .misalign_o(misalign)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .branch_flag_i(1'b0),
    .branch_target_i(32'h0), .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2),
    .rom_data_i(rom_data2), .id_valid_o(id_valid2), .id_ready_i(1'b1),
    .id_pc_o(id_pc2), .id_inst_o(id_inst2), .misalign_o(misalign2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, " valid"}, {31'b0, id_valid}, 32'd1);
    chk({tag, " pc"}, id_pc, pc);
    chk({tag, " inst"}, id_inst, rom(pc));
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; ready = 1'b1;
    tick(); tick();
    // reset state
    chk("rst ce",    {31'b0, rom_ce},   32'd0);
    chk("rst addr",  rom_addr,          32'd0);
    chk("rst valid", {31'b0, id_valid}, 32'd0);
    chk("rst pc",    id_pc,             32'd0);
    chk("rst inst",  id_inst,           32'd0);
    chk("rst mis",   {31'b0, misalign}, 32'd0);

    // 1: release, stream with ready high
    rst = 1'b1; rst2 = 1'b1;
    tick();
    chk("t1 ce",    {31'b0, rom_ce},   32'd1);
    chk("t1 addr",  rom_addr,          32'd0);
    chk("t1 valid", {31'b0, id_valid}, 32'd0);
    tick();
    head("t1 h0", 32'h0);
    chk("t5 wrap0", id_pc2, 32'hFFFF_FFF8);
    tick();
    head("t1 h1", 32'h4);
    chk("t5 wrap1", id_pc2, 32'hFFFF_FFFC);
    tick();
    head("t1 h2", 32'h8);
    chk("t5 wrap2", id_pc2, 32'h0000_0000);
    chk("t5 wrap2 inst", id_inst2, rom(32'h0));

    // 2: back-pressure from a fresh reset
    rst = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    head("t2 full", 32'h0);
    chk("t2 pc hold", rom_addr, 32'h8);
    ready = 1'b1;
    #1 head("t2 d0", 32'h0);
    tick(); head("t2 d1", 32'h4);
    tick(); head("t2 d2", 32'h8);
    tick(); head("t2 d3", 32'hC);

    // 3: redirect while full and ready high
    ready = 1'b0;
    tick(); tick();
    chk("t3 pre addr", rom_addr, 32'h14);
    ready = 1'b1; br = 1'b1; tgt = 32'h40;
    tick();
    br = 1'b0;
    chk("t3 flush valid", {31'b0, id_valid}, 32'd0);
    chk("t3 flush pc",    id_pc,             32'd0);
    chk("t3 addr",        rom_addr,          32'h40);
    chk("t3 mis",         {31'b0, misalign}, 32'd0);
    tick(); head("t3 b0", 32'h40);
    tick(); head("t3 b1", 32'h44);

    // 4: stall drains the FIFO, PC holds
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 valid", {31'b0, id_valid}, 32'd0);
      chk("t4 addr",  rom_addr,          32'h48);
    end
    stall = 1'b0;
    tick(); head("t4 resume", 32'h48);

    // 5: misaligned redirect
    br = 1'b1; tgt = 32'h42;
    tick();
    br = 1'b0;
    chk("t5 mis pulse", {31'b0, misalign}, 32'd1);
    chk("t5 mis valid", {31'b0, id_valid}, 32'd0);
    tick();
    chk("t5 mis clr", {31'b0, misalign}, 32'd0);
    head("t5 aligned", 32'h40);

    // redirect together with stall: taken now, fetch waits for stall release
    br = 1'b1; stall = 1'b1; tgt = 32'h80;
    tick();
    br = 1'b0;
    chk("bs valid", {31'b0, id_valid}, 32'd0);
    chk("bs addr",  rom_addr,          32'h80);
    tick();
    chk("bs hold valid", {31'b0, id_valid}, 32'd0);
    stall = 1'b0;
    tick(); head("bs resume", 32'h80);

    // 6: asynchronous reset with entries pending
    ready = 1'b0;
    tick();
    chk("t6 pre", {31'b0, id_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6 valid", {31'b0, id_valid}, 32'd0);
    chk("t6 ce",    {31'b0, rom_ce},   32'd0);
    chk("t6 addr",  rom_addr,          32'd0);
    chk("t6 pc",    id_pc,             32'd0);
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    tick();
    chk("t6 ce up", {31'b0, rom_ce}, 32'd1);
    tick(); head("t6 restart", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
